memgame_round_ctrl: RTL and testbench

//  Parametrised round sequencer for the memorisation game; replaces the fixed
//  4-digit, single-round flow with a multi-level game whose sequence grows each level.

---
 rtl/memgame_pkg.sv | 29 ++
 rtl/memgame_timer.sv | 37 +++
 rtl/memgame_round_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_memgame_round_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memgame_pkg.sv
// Shared definitions for the memorisation-game round sequencer.
//   state_e      : FSM state encoding (also exported on the debug state output)
//   BCD_BLANK    : digit code that the display renders as blank
//   BCD_MAX      : largest digit the keyboard may enter
//   seq_len()    : sequence length for a given level, clamped to the digit count
package memgame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHOW  = 3'd2,
    ST_ENTER = 3'd3,
    ST_CHECK = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // length = min(min_len + lvl - 1, max_len)
  function automatic int seq_len(input int min_len, input int lvl, input int max_len);
    int l;
    l = min_len + lvl - 1;
    if (l > max_len) l = max_len;
    return l;
  endfunction

endpackage

// File: rtl/memgame_timer.sv
// Loadable down-counter shared by the SHOW phase and the ENTER timeout.
//   clk_i      : clock
//   rst_i      : synchronous active-low reset
//   load_i     : load load_val_i (has priority over counting)
//   load_val_i : value to load
//   en_i       : count down by one per cycle while non-zero
//   done_o     : high during the last counted cycle (count==1 while enabled),
//                so a load of N yields exactly N enabled cycles up to and
//                including the done cycle. A load of 0 never raises done_o.
module memgame_timer
  import memgame_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = en_i && (count_q == W'(1));

endmodule

// File: rtl/memgame_round_ctrl.sv
// Multi-level round sequencer for the memorisation game.
// Latches a random BCD sequence, shows it for SHOW_CYCLES clocks, collects
// keyboard digits, compares them and then advances a level, wins, or loses.
//
// Ports:
//   clk_i / rst_i   : clock, synchronous active-low reset
//   start_i         : begin a game (honoured only in IDLE/WIN/LOSE)
//   rand_in_i       : random BCD digits, sampled only in LOAD
//   key_valid_i     : one-cycle key strobe; key_digit_i 0-9 accepted, >9 ignored
//   disp_value_o    : digits to show (digit 0 in [3:0]), unused digits 4'hF
//   disp_len_o      : active sequence length
//   show_active_o   : high during SHOW
//   enter_active_o  : high during ENTER
//   entry_count_o   : digits entered this round
//   level_o         : current level, 1-based
//   score_o         : sum of cleared sequence lengths, saturating
//   lives_left_o    : remaining lives (0 when lives are compiled out)
//   round_pass_o    : one-cycle pulse after a correct entry
//   game_win_o      : held high in WIN
//   game_over_o     : held high in LOSE
//   state_o         : FSM state, for debug/observation
//
// Build option: define MEMGAME_LIVES_EN to give the player MAX_LIVES tries;
// a wrong entry then replays the same sequence until lives run out.
//
// Handshake: key_valid_i is a strobe with no back-pressure; a key is taken on
// the edge where key_valid_i is high, the FSM is in ENTER, the digit is 0-9
// and the sequence is not yet complete. Any other strobe is dropped.
module memgame_round_ctrl
  import memgame_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int MIN_LEN       = 2,
  parameter int MAX_LEVEL     = 6,
  parameter int SHOW_CYCLES   = 100,
  parameter int ENTER_TIMEOUT = 0,
  parameter int MAX_LIVES     = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [NUM_DIGITS*4-1:0]           rand_in_i,
  input  logic                              key_valid_i,
  input  logic [3:0]                        key_digit_i,
  output logic [NUM_DIGITS*4-1:0]           disp_value_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   disp_len_o,
  output logic                              show_active_o,
  output logic                              enter_active_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_count_o,
  output logic [$clog2(MAX_LEVEL+1)-1:0]    level_o,
  output logic [15:0]                       score_o,
  output logic [$clog2(MAX_LIVES+1)-1:0]    lives_left_o,
  output logic                              round_pass_o,
  output logic                              game_win_o,
  output logic                              game_over_o,
  output logic [2:0]                        state_o
);

  localparam int  DW         = NUM_DIGITS * 4;
  localparam int  CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam int  LVL_W      = $clog2(MAX_LEVEL + 1);
  localparam int  LIVES_W    = $clog2(MAX_LIVES + 1);
  localparam int  TMR_MAX    = (SHOW_CYCLES > ENTER_TIMEOUT) ? SHOW_CYCLES : ENTER_TIMEOUT;
  localparam int  TMR_W      = $clog2(TMR_MAX + 1);
  localparam bit  TIMEOUT_EN = (ENTER_TIMEOUT > 0);
  localparam logic [DW-1:0] ALL_BLANK = {NUM_DIGITS{BCD_BLANK}};

  state_e            state_q;
  logic [DW-1:0]     seq_q;
  logic [DW-1:0]     entry_q;
  logic [CNT_W-1:0]  entry_cnt_q;
  logic [CNT_W-1:0]  len_q;
  logic [LVL_W-1:0]  level_q;
  logic [15:0]       score_q;
  logic              round_pass_q;
  logic              timeout_q;   // entry ended by timeout: forces a mismatch
`ifdef MEMGAME_LIVES_EN
  logic [LIVES_W-1:0] lives_q;
`endif

  logic              key_ok;
  logic [CNT_W-1:0]  entry_cnt_inc;
  logic [DW-1:0]     entry_d;
  logic [CNT_W-1:0]  len_d;
  logic              match;
  logic [16:0]       score_sum;
  logic [15:0]       score_d;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_en;
  logic              tmr_done;
  logic [DW-1:0]     disp_d;

  assign key_ok = (state_q == ST_ENTER) && key_valid_i &&
                  (key_digit_i <= BCD_MAX) && (entry_cnt_q < len_q);
  assign entry_cnt_inc = entry_cnt_q + CNT_W'(1);
  assign len_d = CNT_W'(seq_len(MIN_LEN, int'(level_q), NUM_DIGITS));
  assign score_sum = {1'b0, score_q} + 17'(len_q);
  assign score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Write the incoming key into the slot addressed by the entry counter.
  always_comb begin
    entry_d = entry_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CNT_W'(i) == entry_cnt_q) entry_d[i*4 +: 4] = key_digit_i;
    end
  end

  // Only the first len digits take part in the comparison.
  always_comb begin
    match = !timeout_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((CNT_W'(i) < len_q) && (entry_q[i*4 +: 4] != seq_q[i*4 +: 4])) match = 1'b0;
    end
  end

  // One timer serves both phases: SHOW and ENTER never overlap.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_LOAD:  begin tmr_load = 1'b1; tmr_val = TMR_W'(SHOW_CYCLES); end
      ST_SHOW:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = TMR_W'(ENTER_TIMEOUT); end
      ST_ENTER: if (key_ok) begin tmr_load = 1'b1; tmr_val = TMR_W'(ENTER_TIMEOUT); end
      // Prepares a replay; every other exit of CHECK reloads in LOAD anyway.
      ST_CHECK: begin tmr_load = 1'b1; tmr_val = TMR_W'(SHOW_CYCLES); end
      default:  ;
    endcase
  end

  assign tmr_en = (state_q == ST_SHOW) || (state_q == ST_ENTER);

  memgame_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      seq_q        <= '0;
      entry_q      <= ALL_BLANK;
      entry_cnt_q  <= '0;
      len_q        <= '0;
      level_q      <= LVL_W'(1);
      score_q      <= '0;
      round_pass_q <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef MEMGAME_LIVES_EN
      lives_q      <= LIVES_W'(MAX_LIVES);
`endif
    end else begin
      round_pass_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start_i) begin
            state_q <= ST_LOAD;
            level_q <= LVL_W'(1);
            score_q <= '0;
`ifdef MEMGAME_LIVES_EN
            lives_q <= LIVES_W'(MAX_LIVES);
`endif
          end
        end
        ST_LOAD: begin
          seq_q       <= rand_in_i;
          len_q       <= len_d;
          entry_q     <= ALL_BLANK;
          entry_cnt_q <= '0;
          timeout_q   <= 1'b0;
          state_q     <= ST_SHOW;
        end
        ST_SHOW: begin
          if (tmr_done) state_q <= ST_ENTER;
        end
        ST_ENTER: begin
          // A key in the same cycle as timeout expiry wins.
          if (key_ok) begin
            entry_q     <= entry_d;
            entry_cnt_q <= entry_cnt_inc;
            if (entry_cnt_inc == len_q) state_q <= ST_CHECK;
          end else if (TIMEOUT_EN && tmr_done) begin
            timeout_q <= 1'b1;
            state_q   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (match) begin
            round_pass_q <= 1'b1;
            score_q      <= score_d;
            if (level_q == LVL_W'(MAX_LEVEL)) begin
              state_q <= ST_WIN;
            end else begin
              level_q <= level_q + LVL_W'(1);
              state_q <= ST_LOAD;
            end
          end else begin
`ifdef MEMGAME_LIVES_EN
            lives_q <= lives_q - LIVES_W'(1);
            if (lives_q > LIVES_W'(1)) begin
              // Replay the same sequence; seq_q and len_q are kept.
              entry_q     <= ALL_BLANK;
              entry_cnt_q <= '0;
              timeout_q   <= 1'b0;
              state_q     <= ST_SHOW;
            end else begin
              state_q <= ST_LOSE;
            end
`else
            state_q <= ST_LOSE;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // SHOW displays the sequence, ENTER displays what has been typed so far.
  always_comb begin
    disp_d = ALL_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((state_q == ST_SHOW) && (CNT_W'(i) < len_q)) begin
        disp_d[i*4 +: 4] = seq_q[i*4 +: 4];
      end else if ((state_q == ST_ENTER) && (CNT_W'(i) < entry_cnt_q)) begin
        disp_d[i*4 +: 4] = entry_q[i*4 +: 4];
      end
    end
  end

  assign disp_value_o   = disp_d;
  assign disp_len_o     = len_q;
  assign show_active_o  = (state_q == ST_SHOW);
  assign enter_active_o = (state_q == ST_ENTER);
  assign entry_count_o  = entry_cnt_q;
  assign level_o        = level_q;
  assign score_o        = score_q;
  assign round_pass_o   = round_pass_q;
  assign game_win_o     = (state_q == ST_WIN);
  assign game_over_o    = (state_q == ST_LOSE);
  assign state_o        = state_q;
`ifdef MEMGAME_LIVES_EN
  assign lives_left_o   = lives_q;
`else
  assign lives_left_o   = '0;
`endif

endmodule

// File: tb/tb_memgame_round_ctrl.sv
module tb_memgame_round_ctrl;

  localparam int SHOW_CYC = 8;
`ifdef MEMGAME_LIVES_EN
  localparam int EXP_LIVES = 3;
`else
  localparam int EXP_LIVES = 0;
`endif

  // state codes as seen on state_o
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SHOW = 3'd2, S_ENTER = 3'd3,
                         S_CHECK = 3'd4, S_WIN = 3'd5, S_LOSE = 3'd6;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] rand_in_i;
  logic        key_valid_i;
  logic [3:0]  key_digit_i;
  logic [15:0] disp_value_o;
  logic [2:0]  disp_len_o;
  logic        show_active_o;
  logic        enter_active_o;
  logic [2:0]  entry_count_o;
  logic [1:0]  level_o;
  logic [15:0] score_o;
  logic [1:0]  lives_left_o;
  logic        round_pass_o;
  logic        game_win_o;
  logic        game_over_o;
  logic [2:0]  state_o;

  int tests = 0;
  int errors = 0;
  logic [15:0] exp_q[$];   // expected score after each passed round

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  memgame_round_ctrl #(
    .NUM_DIGITS(4), .MIN_LEN(2), .MAX_LEVEL(3),
    .SHOW_CYCLES(SHOW_CYC), .ENTER_TIMEOUT(0), .MAX_LIVES(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rand_in_i(rand_in_i),
    .key_valid_i(key_valid_i), .key_digit_i(key_digit_i),
    .disp_value_o(disp_value_o), .disp_len_o(disp_len_o),
    .show_active_o(show_active_o), .enter_active_o(enter_active_o),
    .entry_count_o(entry_count_o), .level_o(level_o), .score_o(score_o),
    .lives_left_o(lives_left_o), .round_pass_o(round_pass_o),
    .game_win_o(game_win_o), .game_over_o(game_over_o), .state_o(state_o)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid_i = 1'b1;
    key_digit_i = d;
    step();
    key_valid_i = 1'b0;
  endtask

  // From IDLE/WIN/LOSE: pulse start, land in the first SHOW cycle.
  task automatic start_game(input logic [15:0] r);
    start_i   = 1'b1;
    rand_in_i = r;
    step();
    start_i = 1'b0;
    check_eq("load_state", state_o, S_LOAD);
    check_eq("load_level", level_o, 1);
    check_eq("load_score", score_o, 0);
    step();
  endtask

  // Called in the first SHOW cycle; checks display every cycle and the
  // phase length. poke drives key, start and rand_in mid-SHOW.
  task automatic run_show(input logic [15:0] exp_disp, input logic [2:0] exp_len, input bit poke);
    logic [15:0] saved_rand;
    int n;
    saved_rand = rand_in_i;
    n = 0;
    check_eq("show_len", disp_len_o, exp_len);
    while (show_active_o && n < 50) begin
      check_eq("show_disp", disp_value_o, exp_disp);
      if (poke && n == 3) begin
        key_valid_i = 1'b1;
        key_digit_i = 4'd1;
        start_i     = 1'b1;
        rand_in_i   = 16'h9999;
      end
      step();
      key_valid_i = 1'b0;
      start_i     = 1'b0;
      n++;
    end
    rand_in_i = saved_rand;
    check_eq("show_cycles", n, SHOW_CYC);
    check_eq("enter_after_show", enter_active_o, 1);
    check_eq("entry_after_show", entry_count_o, 0);
    check_eq("enter_disp_blank", disp_value_o, 16'hFFFF);
  endtask

  // Called in the cycle after CHECK for a passing round.
  task automatic check_pass(input logic [1:0] exp_level);
    logic [15:0] exp_score;
    check_eq("round_pass", round_pass_o, 1);
    if (exp_q.size() == 0) begin
      check_eq("score_queue_empty", 1, 0);
    end else begin
      exp_score = exp_q.pop_front();
      check_eq("score", score_o, exp_score);
    end
    check_eq("level", level_o, exp_level);
  endtask

  task automatic check_reset_state();
    check_eq("rst_state", state_o, S_IDLE);
    check_eq("rst_disp", disp_value_o, 16'hFFFF);
    check_eq("rst_len", disp_len_o, 0);
    check_eq("rst_show", show_active_o, 0);
    check_eq("rst_enter", enter_active_o, 0);
    check_eq("rst_entry", entry_count_o, 0);
    check_eq("rst_level", level_o, 1);
    check_eq("rst_score", score_o, 0);
    check_eq("rst_lives", lives_left_o, EXP_LIVES);
    check_eq("rst_pass", round_pass_o, 0);
    check_eq("rst_win", game_win_o, 0);
    check_eq("rst_over", game_over_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i       = 1'b0;
    start_i     = 1'b0;
    rand_in_i   = 16'h0000;
    key_valid_i = 1'b0;
    key_digit_i = 4'd0;
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd9);
    step();
    step();
    rst_i = 1'b1;
    check_reset_state();

    // Game 1, level 1: sequence 4321, length 2
    start_game(16'h4321);
    run_show(16'hFF21, 3'd2, 1'b1);
    press(4'd1);
    check_eq("l1_entry1", entry_count_o, 1);
    check_eq("l1_disp1", disp_value_o, 16'hFFF1);
    press(4'hA);
    check_eq("l1_key_A_ignored", entry_count_o, 1);
    check_eq("l1_still_enter", state_o, S_ENTER);
    press(4'd2);
    check_eq("l1_check", state_o, S_CHECK);
    check_eq("l1_entry2", entry_count_o, 2);
    step();
    check_pass(2'd2);
    check_eq("l1_to_load", state_o, S_LOAD);
    step();
    check_eq("pass_pulse_end", round_pass_o, 0);

    // Level 2: length 3
    run_show(16'hF321, 3'd3, 1'b0);
    press(4'd1); press(4'd2); press(4'd3);
    check_eq("l2_check", state_o, S_CHECK);
    step();
    check_pass(2'd3);
    step();

    // Level 3: length 4, last level
    run_show(16'h4321, 3'd4, 1'b0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    step();
    check_eq("win_state", state_o, S_WIN);
    check_pass(2'd3);
    step();
    check_eq("win_held", game_win_o, 1);
    check_eq("win_pulse_end", round_pass_o, 0);
    check_eq("score_queue_drained", exp_q.size(), 0);

    // Game 2 from WIN: level/score restart, wrong second digit
    start_game(16'h5678);
    check_eq("win_cleared", game_win_o, 0);
    run_show(16'hFF78, 3'd2, 1'b0);
    press(4'd8);
    press(4'd9);
    check_eq("g2_check", state_o, S_CHECK);
    step();
    check_eq("fail_no_pass", round_pass_o, 0);
    check_eq("fail_score", score_o, 0);
`ifdef MEMGAME_LIVES_EN
    check_eq("replay_state", state_o, S_SHOW);
    check_eq("replay_lives", lives_left_o, 2);
    check_eq("replay_over", game_over_o, 0);
    run_show(16'hFF78, 3'd2, 1'b0);
    press(4'd8);
    check_eq("replay_entry", entry_count_o, 1);
    check_eq("replay_disp", disp_value_o, 16'hFFF8);
`else
    check_eq("lose_state", state_o, S_LOSE);
    check_eq("game_over", game_over_o, 1);
    check_eq("lose_lives", lives_left_o, 0);
    step();
    check_eq("game_over_held", game_over_o, 1);
    // Game 3 from LOSE, stop mid-ENTER
    start_game(16'h1234);
    run_show(16'hFF34, 3'd2, 1'b0);
    press(4'd4);
    check_eq("g3_entry", entry_count_o, 1);
    check_eq("g3_disp", disp_value_o, 16'hFFF4);
`endif

    // Reset pulse mid-ENTER
    check_eq("pre_rst_enter", enter_active_o, 1);
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    check_reset_state();
    step();
    check_eq("idle_hold", state_o, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
